// File: rtl/mult_div_unit_if.sv
// E-stage multiply/divide unit bundle: op/operands/read-select in, HI/LO/status out.
// master drives the op side (pipeline/bench), slave is the unit itself.
interface mult_div_unit_if;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [1:0]  E_MDRead;
  logic        D_MDUse;
  logic [31:0] E_MDOut;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        D_MDStall;

  modport master (
    output E_MDOp, E_A, E_B, E_MDRead, D_MDUse,
    input  E_MDOut, busy, HI, LO, D_MDStall
  );

  modport slave (
    input  E_MDOp, E_A, E_B, E_MDRead, D_MDUse,
    output E_MDOut, busy, HI, LO, D_MDStall
  );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU 5 cycles, DIV/DIVU 10 cycles (divide only with MDU_DIV_EN).
// No backpressure input; D_MDStall holds D-stage md users while an op starts or is in flight.
module mult_div_unit (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave md
);
  localparam logic [3:0] OP_MULT    = 4'd1;
  localparam logic [3:0] OP_MULTU   = 4'd2;
  localparam logic [3:0] OP_MTHI    = 4'd5;
  localparam logic [3:0] OP_MTLO    = 4'd6;
  localparam logic [3:0] MUL_CYCLES = 4'd5;
`ifdef MDU_DIV_EN
  localparam logic [3:0] OP_DIV     = 4'd3;
  localparam logic [3:0] OP_DIVU    = 4'd4;
  localparam logic [3:0] DIV_CYCLES = 4'd10;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  op, op_nxt;
  logic [31:0] op_a, op_a_nxt;
  logic [31:0] op_b, op_b_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;

  logic        op_is_mul, op_is_div, start;
  logic        res_wr;
  logic [31:0] res_hi, res_lo;
  logic [63:0] mul_s, mul_u;

  assign op_is_mul = (md.E_MDOp == OP_MULT) || (md.E_MDOp == OP_MULTU);
`ifdef MDU_DIV_EN
  assign op_is_div = (md.E_MDOp == OP_DIV) || (md.E_MDOp == OP_DIVU);
`else
  assign op_is_div = 1'b0;
`endif
  assign start = (state == IDLE) && (op_is_mul || op_is_div);

  // Sign-extended operands make the low 64 bits the exact signed product.
  assign mul_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign mul_u = {32'd0, op_a} * {32'd0, op_b};

`ifdef MDU_DIV_EN
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  // Magnitude divide then re-sign: quotient truncates toward zero, remainder
  // takes the dividend's sign, and 0x80000000 / -1 falls out as 0x80000000.
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & op_a[31];
  assign b_neg      = div_signed & op_b[31];
  assign a_mag      = a_neg ? (~op_a + 32'd1) : op_a;
  assign b_mag      = b_neg ? (~op_b + 32'd1) : op_b;
  assign q_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign div_q      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign div_r      = a_neg ? (~r_mag + 32'd1) : r_mag;
`endif

  always_comb begin
    res_wr = 1'b0;
    res_hi = hi;
    res_lo = lo;
    case (op)
      OP_MULT: begin
        res_wr           = 1'b1;
        {res_hi, res_lo} = mul_s;
      end
      OP_MULTU: begin
        res_wr           = 1'b1;
        {res_hi, res_lo} = mul_u;
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        res_wr = (op_b != 32'd0);
        res_hi = div_r;
        res_lo = div_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          op_nxt    = md.E_MDOp;
          op_a_nxt  = md.E_A;
          op_b_nxt  = md.E_B;
`ifdef MDU_DIV_EN
          cnt_nxt   = op_is_div ? DIV_CYCLES : MUL_CYCLES;
`else
          cnt_nxt   = MUL_CYCLES;
`endif
        end else if (md.E_MDOp == OP_MTHI) begin
          hi_nxt = md.E_A;
        end else if (md.E_MDOp == OP_MTLO) begin
          lo_nxt = md.E_A;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op    <= 4'd0;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
      op_a  <= op_a_nxt;
      op_b  <= op_b_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign md.busy      = (state == BUSY);
  assign md.HI        = hi;
  assign md.LO        = lo;
  assign md.D_MDStall = md.D_MDUse & (md.busy | start);
  assign md.E_MDOut   = (md.E_MDRead == 2'd1) ? hi :
                        (md.E_MDRead == 2'd2) ? lo : 32'd0;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: E_MDOp  in  4  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others none.
REQ-004 SHALL have ports: E_A  in  32  forwarded rs value; E_B  in  32  forwarded rt value.
REQ-005 SHALL have ports: E_MDRead  in  2  read select: 0 none, 1 HI (mfhi), 2 LO (mflo), 3 none.
REQ-006 SHALL have ports: D_MDUse  in  1  D-stage instruction is any of ops 1-6 or mfhi/mflo.
REQ-007 SHALL have ports: E_MDOut  out  32  HI when E_MDRead=1, LO when 2, else 0.
REQ-008 SHALL have ports: busy  out  1  operation in flight; HI  out  32; LO  out  32.
REQ-009 SHALL have ports: D_MDStall  out  1  stall request to F/D and D/E registers.

Function
REQ-010 SHALL implement two states, IDLE and BUSY, plus 4-bit cycle counter cnt.
REQ-011 start SHALL be combinational: E_MDOp in 1-4 while state=IDLE.
REQ-012 On edge with start, SHALL latch E_A, E_B, op; enter BUSY; load cnt=5 (MULT/MULTU) or 10 (DIV/DIVU).
REQ-013 In BUSY, cnt SHALL decrement each edge; on the edge where cnt=1, SHALL write HI/LO, return to IDLE, cnt=0.
REQ-014 busy SHALL equal (state==BUSY); high exactly 5 cycles for multiply, 10 for divide, starting cycle after start.
REQ-015 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-016 DIV: LO = quotient truncated toward zero, HI = remainder with dividend sign; DIVU unsigned.
REQ-017 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 Divisor 0 SHALL run full 10 busy cycles and leave HI/LO unchanged.
REQ-019 MTHI/MTLO SHALL write E_A to HI/LO on the edge, only when state=IDLE; ignored in BUSY.
REQ-020 Ops 1-4 arriving while BUSY SHALL be ignored (no restart, no operand capture).
REQ-021 E_MDOut SHALL be combinational from current HI/LO registers (no bypass of in-flight result).
REQ-022 D_MDStall SHALL equal D_MDUse & (busy | start).
REQ-023 HI/LO SHALL change only per REQ-013, REQ-019, or reset.

Reset
REQ-024 reset low SHALL immediately force state=IDLE, cnt=0, HI=0, LO=0, latched operands=0, busy=0, D_MDStall=0 (given D_MDUse=0 not required).
REQ-025 reset asserted mid-operation SHALL discard the in-flight result; first edge after release starts from IDLE.

Configuration
REQ-026 Macro MDU_DIV_EN SHALL control divide support.
REQ-027 With MDU_DIV_EN defined: behaviour per REQ-012..018.
REQ-028 Without MDU_DIV_EN: ops 3/4 SHALL be treated as none (no start, no busy, HI/LO unchanged, no stall); no divider logic synthesised.

Verification
REQ-029 MULT A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 MULTU A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 DIV A=0xFFFFFFF9, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, HI/LO unchanged.
REQ-032 MTHI A=0x12345678 during MULT busy with D_MDUse=1 -> D_MDStall=1 every busy cycle, HI not 0x12345678 after completion; MTHI in IDLE -> E_MDRead=1 returns 0x12345678 next cycle.
REQ-033 reset low in 3rd busy cycle of MULT -> busy, HI, LO = 0 without clock edge; no later write.
REQ-034 Build without MDU_DIV_EN, E_MDOp=3 -> busy stays 0, D_MDStall=0 with D_MDUse=1, HI/LO unchanged.
